// File: rtl/pc_stream_monitor_pkg.sv
// Shared types for the fetch PC stream monitor: end-of-program FSM state encoding.
package pc_stream_monitor_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    DONE    = 2'd2,
    TIMEOUT = 2'd3
  } monitor_state_e;

endpackage : pc_stream_monitor_pkg

// File: rtl/pc_stream_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] value_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every always_comb output gets its default first so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value_o = cnt_q;

endmodule : sat_counter

// File: rtl/pc_stream_monitor.sv
// Run-time fetch PC stream monitor: registered PC check, de-duplicated mispredict count,
// and a RUN->DRAIN->DONE/TIMEOUT end-of-program FSM.
module pc_stream_monitor
  import pc_stream_monitor_pkg::*;
#(
  parameter int unsigned       XLEN          = 32,
  parameter int unsigned       PC_STEP       = 4,
  parameter logic [XLEN-1:0]   RESET_PC      = '0,
  parameter int unsigned       TAG_W         = 5,
  parameter int unsigned       CNT_W         = 16,
  parameter int unsigned       DRAIN_CYCLES  = 50,
  parameter int unsigned       MAX_CYCLES    = 1000,
  parameter bit                REQ_ROB_EMPTY = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch_fire,
  input  logic [XLEN-1:0]  fetch_pc,
  input  logic             fetch_instr_ok,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  input  logic             mispredict,
  input  logic [TAG_W-1:0] mispredict_tag,
  input  logic             rob_empty,
  output logic             pc_err,
  output logic             pc_err_sticky,
  output logic [XLEN-1:0]  first_err_exp,
  output logic [XLEN-1:0]  first_err_got,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] mp_cnt,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic             done,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CYC_LAST  = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_MIN = CNT_W'(DRAIN_CYCLES);
  localparam logic [XLEN-1:0]  STEP      = XLEN'(PC_STEP);

  monitor_state_e   state_q, state_d;
  logic [XLEN-1:0]  exp_pc_q, exp_pc_d;
  logic [XLEN-1:0]  first_exp_q, first_exp_d;
  logic [XLEN-1:0]  first_got_q, first_got_d;
  logic             pc_err_q, pc_err_d;
  logic             sticky_q, sticky_d;
  logic             mp_prev_q;
  logic [TAG_W-1:0] last_tag_q;
  logic [CNT_W-1:0] cyc_cnt, drain_cnt;

  logic in_run, in_drain, active;
  logic pc_check, pc_mismatch, mp_event;

  assign in_run   = (state_q == RUN);
  assign in_drain = (state_q == DRAIN);
  assign active   = in_run || in_drain;

  // Fetches fired alongside a redirect are wrong-path and never compared.
  assign pc_check    = in_run && fetch_fire && !redirect_valid;
  assign pc_mismatch = pc_check && (fetch_pc != exp_pc_q);
  assign mp_event    = active && mispredict && (!mp_prev_q || (mispredict_tag != last_tag_q));

  // Expected-PC tracking and first-error capture.
  always_comb begin
    exp_pc_d    = exp_pc_q;
    pc_err_d    = pc_mismatch;
    sticky_d    = sticky_q || pc_mismatch;
    first_exp_d = first_exp_q;
    first_got_d = first_got_q;
    if (active && redirect_valid) begin
      exp_pc_d = redirect_pc;
    end else if (pc_check) begin
      // Resync on the PC actually fetched so one break yields one error.
      exp_pc_d = fetch_pc + STEP;
    end
    if (pc_mismatch && !sticky_q) begin
      first_exp_d = exp_pc_q;
      first_got_d = fetch_pc;
    end
  end

  // End-of-program FSM; timeout overrides every RUN/DRAIN transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (fetch_fire && !fetch_instr_ok && !redirect_valid) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (redirect_valid) begin
          state_d = RUN;
        end else if ((drain_cnt >= DRAIN_MIN) && (rob_empty || !REQ_ROB_EMPTY)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = DONE;
      TIMEOUT: state_d = TIMEOUT;
      default: state_d = RUN;
    endcase
    if (active && (cyc_cnt == CYC_LAST)) begin
      state_d = TIMEOUT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      exp_pc_q    <= RESET_PC;
      first_exp_q <= '0;
      first_got_q <= '0;
      pc_err_q    <= 1'b0;
      sticky_q    <= 1'b0;
      mp_prev_q   <= 1'b0;
      last_tag_q  <= '0;
    end else begin
      state_q     <= state_d;
      exp_pc_q    <= exp_pc_d;
      first_exp_q <= first_exp_d;
      first_got_q <= first_got_d;
      pc_err_q    <= pc_err_d;
      sticky_q    <= sticky_d;
      mp_prev_q   <= mispredict;
      last_tag_q  <= mispredict_tag;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (1'b0),
    .inc_i   (pc_mismatch),
    .value_o (err_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_mp_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (1'b0),
    .inc_i   (mp_event),
    .value_o (mp_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_fetch_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (1'b0),
    .inc_i   (in_run && fetch_fire),
    .value_o (fetch_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cyc_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (1'b0),
    .inc_i   (1'b1),
    .value_o (cyc_cnt)
  );

  // Held at zero outside DRAIN, so it always starts from 0 on entry.
  sat_counter #(.CNT_W(CNT_W)) u_drain_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (!in_drain),
    .inc_i   (in_drain),
    .value_o (drain_cnt)
  );

  assign pc_err        = pc_err_q;
  assign pc_err_sticky = sticky_q;
  assign first_err_exp = first_exp_q;
  assign first_err_got = first_got_q;
  assign done          = (state_q == DONE);
  assign timeout       = (state_q == TIMEOUT);

endmodule : pc_stream_monitor

// File: tb/tb_pc_stream_monitor.sv
// Scoreboard bench for pc_stream_monitor: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_pc_stream_monitor;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAG_W = 5;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             fetch_fire;
  logic [XLEN-1:0]  fetch_pc;
  logic             fetch_instr_ok;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic             mispredict;
  logic [TAG_W-1:0] mispredict_tag;
  logic             rob_empty;
  logic             pc_err;
  logic             pc_err_sticky;
  logic [XLEN-1:0]  first_err_exp;
  logic [XLEN-1:0]  first_err_got;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] mp_cnt;
  logic [CNT_W-1:0] fetch_cnt;
  logic             done;
  logic             timeout;

  pc_stream_monitor dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_fire     (fetch_fire),
    .fetch_pc       (fetch_pc),
    .fetch_instr_ok (fetch_instr_ok),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mispredict     (mispredict),
    .mispredict_tag (mispredict_tag),
    .rob_empty      (rob_empty),
    .pc_err         (pc_err),
    .pc_err_sticky  (pc_err_sticky),
    .first_err_exp  (first_err_exp),
    .first_err_got  (first_err_got),
    .err_cnt        (err_cnt),
    .mp_cnt         (mp_cnt),
    .fetch_cnt      (fetch_cnt),
    .done           (done),
    .timeout        (timeout)
  );

  always #5 clk = ~clk;

  int unsigned tb_cyc = 0;
  int unsigned run_base = 0;
  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  typedef enum {S_PC_ERR, S_STICKY, S_EXP, S_GOT, S_ERR_CNT, S_MP_CNT,
                S_FETCH_CNT, S_DONE, S_TIMEOUT} sig_e;

  typedef struct {
    int unsigned at;
    sig_e        sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] dut_val(sig_e s);
    case (s)
      S_PC_ERR:    return {31'd0, pc_err};
      S_STICKY:    return {31'd0, pc_err_sticky};
      S_EXP:       return first_err_exp;
      S_GOT:       return first_err_got;
      S_ERR_CNT:   return {16'd0, err_cnt};
      S_MP_CNT:    return {16'd0, mp_cnt};
      S_FETCH_CNT: return {16'd0, fetch_cnt};
      S_DONE:      return {31'd0, done};
      default:     return {31'd0, timeout};
    endcase
  endfunction

  // Monitor: compares every expectation due this cycle against the settled outputs.
  always @(negedge clk) begin : monitor
    int idx;
    logic [31:0] got;
    idx = 0;
    while (idx < sb_q.size()) begin
      if (sb_q[idx].at == tb_cyc) begin
        got = dut_val(sb_q[idx].sig);
        checks++;
        if (got !== sb_q[idx].val) begin
          errors++;
          $display("FAIL %s (dut cycle %0d): got 0x%0h, expected 0x%0h",
                   sb_q[idx].name, tb_cyc - run_base, got, sb_q[idx].val);
        end
        sb_q.delete(idx);
      end else if (sb_q[idx].at < tb_cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: expectation for cycle %0d never compared", sb_q[idx].name, sb_q[idx].at);
        sb_q.delete(idx);
      end else begin
        idx++;
      end
    end
  end

  task automatic expect_at(input int unsigned dly, input sig_e s, input logic [31:0] v,
                           input string n);
    exp_t e;
    e.at   = tb_cyc + dly;
    e.sig  = s;
    e.val  = v;
    e.name = n;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fetch_fire     = 1'b0;
    fetch_pc       = '0;
    fetch_instr_ok = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mispredict     = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    tick();
    tick();
    reset = 1'b1;
    tick();
    tick();
    reset    = 1'b0;
    run_base = tb_cyc;
  endtask

  task automatic idle_until(input int unsigned dc);
    idle_inputs();
    while ((tb_cyc - run_base) < dc) tick();
  endtask

  task automatic fire(input logic [31:0] pc, input logic ok, input logic exp_err);
    fetch_fire     = 1'b1;
    fetch_pc       = pc;
    fetch_instr_ok = ok;
    expect_at(1, S_PC_ERR, {31'd0, exp_err}, "pc_err");
    tick();
    idle_inputs();
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    idle_inputs();
  endtask

  task automatic expect_zero_state(input string tag);
    expect_at(0, S_PC_ERR,    0, {tag, "_pc_err"});
    expect_at(0, S_STICKY,    0, {tag, "_sticky"});
    expect_at(0, S_EXP,       0, {tag, "_first_exp"});
    expect_at(0, S_GOT,       0, {tag, "_first_got"});
    expect_at(0, S_ERR_CNT,   0, {tag, "_err_cnt"});
    expect_at(0, S_MP_CNT,    0, {tag, "_mp_cnt"});
    expect_at(0, S_FETCH_CNT, 0, {tag, "_fetch_cnt"});
    expect_at(0, S_DONE,      0, {tag, "_done"});
    expect_at(0, S_TIMEOUT,   0, {tag, "_timeout"});
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    reset          = 1'b1;
    rob_empty      = 1'b1;
    mispredict_tag = '0;
    idle_inputs();

    // Run A: PC checking, redirect, wrap, mispredict de-dup, DRAIN ignores fires.
    do_reset();
    expect_zero_state("reset");
    fire(32'h0, 1'b1, 1'b0);
    fire(32'h4, 1'b1, 1'b0);
    fire(32'h8, 1'b1, 1'b0);
    fire(32'hC, 1'b1, 1'b0);
    expect_at(0, S_FETCH_CNT, 4, "seq_fetch_cnt");
    expect_at(0, S_ERR_CNT,   0, "seq_err_cnt");
    expect_at(0, S_STICKY,    0, "seq_sticky");

    redirect(32'h0);
    fire(32'h0,  1'b1, 1'b0);
    fire(32'h4,  1'b1, 1'b0);
    fire(32'h10, 1'b1, 1'b1);
    fire(32'h14, 1'b1, 1'b0);
    expect_at(0, S_STICKY,  1,     "break_sticky");
    expect_at(0, S_EXP,     32'h8, "break_first_exp");
    expect_at(0, S_GOT,     32'h10, "break_first_got");
    expect_at(0, S_ERR_CNT, 1,     "break_err_cnt");

    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    fire(32'h8, 1'b1, 1'b0);
    fire(32'h40, 1'b1, 1'b0);
    fire(32'h48, 1'b1, 1'b1);
    expect_at(0, S_ERR_CNT, 2,      "redir_err_cnt");
    expect_at(0, S_EXP,     32'h8,  "redir_first_exp_held");
    expect_at(0, S_GOT,     32'h10, "redir_first_got_held");

    redirect(32'hFFFF_FFFC);
    fire(32'hFFFF_FFFC, 1'b1, 1'b0);
    fire(32'h0, 1'b1, 1'b0);
    expect_at(0, S_ERR_CNT, 2, "wrap_err_cnt");

    mispredict = 1'b1; mispredict_tag = 5'd7;
    tick(); tick(); tick();
    mispredict = 1'b0;
    tick();
    mispredict = 1'b1; mispredict_tag = 5'd7;
    tick();
    mispredict_tag = 5'd9;
    tick(); tick();
    mispredict = 1'b0;
    expect_at(0, S_MP_CNT,    3,  "mp_cnt");
    expect_at(0, S_FETCH_CNT, 13, "run_fetch_cnt");
    tick();

    fire(32'h4, 1'b0, 1'b0);
    expect_at(0, S_DONE,      0,  "drain_not_done");
    expect_at(0, S_FETCH_CNT, 14, "end_fetch_cnt");
    fire(32'h100, 1'b1, 1'b0);
    expect_at(0, S_FETCH_CNT, 14, "drain_fetch_ignored");
    expect_at(0, S_ERR_CNT,   2,  "drain_err_cnt");
    tick();

    // Run B: end of program at cycle 20, ROB drains at cycle 90.
    do_reset();
    rob_empty = 1'b0;
    idle_until(20);
    fire(32'h0, 1'b0, 1'b0);
    idle_until(71);
    expect_at(0, S_DONE, 0, "rob_wait_done");
    idle_until(90);
    rob_empty = 1'b1;
    expect_at(0, S_DONE, 0, "rob_c90_done");
    tick();
    expect_at(0, S_DONE,    1, "rob_c91_done");
    expect_at(0, S_TIMEOUT, 0, "rob_c91_timeout");
    fire(32'h200, 1'b1, 1'b0);
    expect_at(0, S_ERR_CNT,   0, "done_err_frozen");
    expect_at(0, S_FETCH_CNT, 1, "done_fetch_frozen");
    tick();

    // Run C: DRAIN aborted by redirect, then minimum DRAIN length with ROB already empty.
    do_reset();
    rob_empty = 1'b1;
    idle_until(10);
    fire(32'h0, 1'b0, 1'b0);
    idle_until(15);
    redirect(32'h80);
    idle_until(20);
    fire(32'h80, 1'b0, 1'b0);
    idle_until(71);
    expect_at(0, S_DONE, 0, "drain_c71_done");
    tick();
    expect_at(0, S_DONE, 1, "drain_c72_done");
    tick();

    // Run D: timeout, then reset in the middle of a second run.
    do_reset();
    idle_until(999);
    expect_at(0, S_TIMEOUT, 0, "to_c999_timeout");
    tick();
    expect_at(0, S_TIMEOUT, 1, "to_c1000_timeout");
    expect_at(0, S_DONE,    0, "to_c1000_done");
    tick();

    do_reset();
    fire(32'h0, 1'b1, 1'b0);
    fire(32'h8, 1'b1, 1'b1);
    mispredict = 1'b1; mispredict_tag = 5'd3;
    tick();
    idle_until(499);
    expect_at(0, S_ERR_CNT,   1, "mid_err_cnt");
    expect_at(0, S_MP_CNT,    1, "mid_mp_cnt");
    expect_at(0, S_FETCH_CNT, 2, "mid_fetch_cnt");
    expect_at(0, S_GOT,       32'h8, "mid_first_got");
    tick();
    reset = 1'b1;
    expect_zero_state("midreset");
    tick();
    tick();
    reset = 1'b0;
    tick();

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_pc_stream_monitor
